// File: rtl/vga_scan_controller.sv
// VGA 640x480@60 scan source: free-running counters, field-memory fetch, aligned pixel/sync outputs.
// Latency: X/Y/ent 2 clocks, HS/VS/BLANK_N 3 clocks from the counters; frame tick is undelayed.
// Backpressure: none; free-running at the pixel clock, and field memory must answer every cycle.
module vga_scan_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int H_SQUARE  = 16,
  parameter int V_SQUARE  = 16,
  parameter int ADDR_W    = 11
) (
  input  logic              iVGA_CLK,
  input  logic              reset,
  output logic [ADDR_W-1:0] oField_Addr,
  input  logic [1:0]        iField_Data,
  output logic [9:0]        oVGA_X,
  output logic [9:0]        oVGA_Y,
  output logic [1:0]        oEnt,
  output logic              oHS,
  output logic              oVS,
  output logic              oBLANK_N,
  output logic              oFrame_Tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END   = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Cells are powers of two, so the divides are shifts; the row stride is a constant multiply.
  localparam int H_SH = $clog2(H_SQUARE);
  localparam int V_SH = $clog2(V_SQUARE);
  localparam logic [ADDR_W-1:0] COLS = ADDR_W'(H_VISIBLE / H_SQUARE);

  // Stage 0: raster counters
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  // Stage 0 combinational decode
  logic              vis0;
  logic              hs_raw0;
  logic              vs_raw0;
  logic [ADDR_W-1:0] addr0;

  // Stage 1
  logic [ADDR_W-1:0] addr1;
  logic [9:0]        x1;
  logic [9:0]        y1;
  logic              vis1;
  logic              hs1;
  logic              vs1;

  // Stage 2
  logic [9:0]        x2;
  logic [9:0]        y2;
  logic              vis2;
  logic              hs2;
  logic              vs2;

  // Stage 3: matches the renderer's RGB output register
  logic              hs3;
  logic              vs3;
  logic              blank_n3;

  // Raster counters: h wraps every line, v advances only on an h wrap.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Visibility, raw sync flags and row-major cell index for the current counters.
  always_comb begin
    vis0    = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    hs_raw0 = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    vs_raw0 = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
    addr0   = '0;
    if (vis0) begin
      addr0 = ADDR_W'(v_cnt >> V_SH) * COLS + ADDR_W'(h_cnt >> H_SH);
    end
  end

  // Stage 1: issue the field read and carry position/flags alongside it.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      addr1 <= '0;
      x1    <= '0;
      y1    <= '0;
      vis1  <= 1'b0;
      hs1   <= 1'b1;
      vs1   <= 1'b1;
    end else begin
      addr1 <= addr0;
      x1    <= h_cnt;
      y1    <= v_cnt;
      vis1  <= vis0;
      hs1   <= hs_raw0;
      vs1   <= vs_raw0;
    end
  end

  // Stage 2: position registers, aligned with the memory's registered read data.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      x2   <= '0;
      y2   <= '0;
      vis2 <= 1'b0;
      hs2  <= 1'b1;
      vs2  <= 1'b1;
    end else begin
      x2   <= vis1 ? x1 : 10'd0;
      y2   <= vis1 ? y1 : 10'd0;
      vis2 <= vis1;
      hs2  <= hs1;
      vs2  <= vs1;
    end
  end

  // Stage 3: delay sync and blank one more clock to match the renderer's RGB register.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      hs3      <= 1'b1;
      vs3      <= 1'b1;
      blank_n3 <= 1'b0;
    end else begin
      hs3      <= hs2;
      vs3      <= vs2;
      blank_n3 <= vis2;
    end
  end

  // The field memory's synchronous read is the stage-2 register for the entity code,
  // so it only needs gating here; data fetched for blanking addresses is discarded.
  assign oEnt        = vis2 ? iField_Data : 2'b00;
  assign oField_Addr = addr1;
  assign oVGA_X      = x2;
  assign oVGA_Y      = y2;
  assign oHS         = hs3;
  assign oVS         = vs3;
  assign oBLANK_N    = blank_n3;
  assign oFrame_Tick = (h_cnt == 10'd0) && (v_cnt == V_VIS_END);

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench for vga_scan_controller: reset, address mapping, entity alignment, sync timing, tick.
// Vertical visible area is shortened to 34 lines (40-line frame, 32000 clocks) to keep runs short.
// Field memory model: 1-clock synchronous read returning addr[1:0], or 2'b11 when forced.
module tb_vga_scan_controller;

  localparam int HT = 800;
  localparam int VT = 40;
  localparam int FRAME = HT * VT;
  localparam int KMAX = 2 * FRAME + 3;

  logic        clk;
  logic        reset;
  logic [10:0] fld_addr;
  logic [1:0]  fld_dat;
  logic [9:0]  vga_x;
  logic [9:0]  vga_y;
  logic [1:0]  ent;
  logic        hs;
  logic        vs;
  logic        blank_n;
  logic        tick;
  logic        force_ent;

  int n_chk;
  int n_err;

  vga_scan_controller #(
    .V_VISIBLE(34),
    .V_FRONT(2),
    .V_SYNC(2),
    .V_BACK(2)
  ) dut (
    .iVGA_CLK(clk),
    .reset(reset),
    .oField_Addr(fld_addr),
    .iField_Data(fld_dat),
    .oVGA_X(vga_x),
    .oVGA_Y(vga_y),
    .oEnt(ent),
    .oHS(hs),
    .oVS(vs),
    .oBLANK_N(blank_n),
    .oFrame_Tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field memory: synchronous read, one clock latency.
  always @(posedge clk) fld_dat <= force_ent ? 2'b11 : fld_addr[1:0];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Visibility of the counters after c clock edges since reset release.
  function automatic bit vis_at(input int c);
    int h;
    int v;
    if (c < 0) return 1'b0;
    h = c % HT;
    v = (c / HT) % VT;
    return (h < 640) && (v < 34);
  endfunction

  initial begin
    int hs_low_line;
    int blank_hi_line;
    int vs_low_frame;
    int hs_falls_frame;
    int vs_falls;
    int ticks;
    int tick_a;
    int tick_b;
    int fall_a;
    int fall_b;
    int first_fall;
    int leak;
    bit hs_prev;
    bit vs_prev;

    n_chk = 0;
    n_err = 0;
    force_ent = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("init_hs", hs, 1);
    chk("init_blank", blank_n, 0);
    reset = 1'b0;

    // Run to counters (300,10), then reset asynchronously mid-line.
    repeat (8300) @(negedge clk);
    chk("pre_blank", blank_n, 1);
    chk("pre_x", vga_x, 298);
    chk("pre_y", vga_y, 10);
    #2 reset = 1'b1;
    #1;
    chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 1);
    chk("rst_blank", blank_n, 0);
    chk("rst_ent", ent, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_addr", fld_addr, 0);
    chk("rst_tick", tick, 0);
    @(negedge clk);
    reset = 1'b0;

    hs_low_line = 0; blank_hi_line = 0; vs_low_frame = 0; hs_falls_frame = 0;
    vs_falls = 0; ticks = 0; tick_a = -1; tick_b = -1;
    fall_a = -1; fall_b = -1; first_fall = -1; leak = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;

    for (int k = 1; k <= KMAX; k++) begin
      @(negedge clk);
      case (k)
        1:     chk("blank_k1", blank_n, 0);
        2:     begin chk("blank_k2", blank_n, 0); chk("x_k2", vga_x, 0); chk("y_k2", vga_y, 0); end
        3:     begin chk("blank_k3", blank_n, 1); chk("x_k3", vga_x, 1); end
        16:    chk("addr_h15", fld_addr, 0);
        17:    chk("addr_h16", fld_addr, 1);
        34:    begin chk("ent_32_0", ent, 2); chk("x_32_0", vga_x, 32); end
        640:   chk("addr_639_0", fld_addr, 39);
        641:   chk("addr_640_0", fld_addr, 0);
        26418: chk("addr_17_33", fld_addr, 81);
        26419: begin chk("x_17_33", vga_x, 17); chk("y_17_33", vga_y, 33); chk("ent_17_33", ent, 1); end
        27040: chk("addr_639_33", fld_addr, 119);
        27199: chk("tick_before", tick, 0);
        27200: chk("tick_at", tick, 1);
        27201: chk("tick_after", tick, 0);
        32001: begin chk("wrap_hs", hs, 1); chk("wrap_vs", vs, 1); chk("wrap_blank", blank_n, 0); end
        32003: begin chk("wrap_blank_on", blank_n, 1); chk("wrap_hs2", hs, 1); chk("wrap_vs2", vs, 1); end
        32641: begin chk("x_639_0", vga_x, 639); chk("y_639_0", vga_y, 0); end
        32807: begin chk("x_5_1", vga_x, 5); chk("y_5_1", vga_y, 1); end
        default: ;
      endcase

      if (k >= 800 && k < 1600) begin
        if (!hs) hs_low_line++;
        if (blank_n) blank_hi_line++;
      end
      if (hs_prev && !hs) begin
        if (first_fall < 0) first_fall = k;
        if (k >= 800 && fall_a < 0) fall_a = k;
        else if (fall_a >= 0 && fall_b < 0) fall_b = k;
        if (k >= FRAME && k < 2 * FRAME) hs_falls_frame++;
      end
      if (k >= FRAME && k < 2 * FRAME && !vs) vs_low_frame++;
      if (vs_prev && !vs) vs_falls++;
      if (tick) begin
        ticks++;
        if (tick_a < 0) tick_a = k; else tick_b = k;
      end
      if (ent != 2'b00 && !vis_at(k - 2)) leak++;
      hs_prev = hs;
      vs_prev = vs;

      // Force 2'b11 from memory on reads that land in blanking (first frame only).
      force_ent = (k < FRAME) && !vis_at(k - 1);
    end

    chk("hs_first_fall", first_fall, 659);
    chk("hs_fall_line1", fall_a, 1459);
    chk("hs_period", fall_b - fall_a, 800);
    chk("hs_low_width", hs_low_line, 96);
    chk("blank_hi_line", blank_hi_line, 640);
    chk("hs_falls_frame", hs_falls_frame, 40);
    chk("vs_low_frame", vs_low_frame, 1600);
    chk("vs_falls", vs_falls, 2);
    chk("tick_count", ticks, 2);
    chk("tick_period", tick_b - tick_a, FRAME);
    chk("ent_blank_leak", leak, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
